nucleic_acid_valve_sequencer: RTL and testbench
===============================================

// Module: nucleic_acid_valve_sequencer
// PURPOSE
//   Digital controller that drives the pneumatic control lines of the nucleic_acid_3 chip.
//   Drives every air_in input: lysis, wash, elute, vertical, bead_trap, collection and waste.
//   Also drives the 3-valve peristaltic pump (pump1..3).
//   Runs the fixed LYSIS -> WASH -> ELUTE protocol after a start request.
//   Sits between the host register block and the off-chip solenoid driver.
//   Control-line convention: 1 = pressurised = valve CLOSED, 0 = valve open.
// PARAMETERS
//   PHASE_CYC      8    clk cycles per pump phase (>=1)
//   PHASE_W        16   width of phase-cycle counter
//   STROKE_W       8    width of stroke counter / stroke parameters
//   LYSIS_STROKES  16   pump strokes in LYSIS step (0 = step skipped)
//   WASH_STROKES   8    pump strokes in WASH step (0 = step skipped)
//   ELUTE_STROKES  4    pump strokes in ELUTE step (0 = step skipped)
// PORTS
//   clk            in   1         single clock
//   rst_n          in   1         async active-low reset
//   start          in   1         begin protocol; sampled only in IDLE
//   abort          in   1         abandon protocol, close all valves
//   busy           out  1         1 in LYSIS..ELUTE incl. SETTLE states
//   done           out  1         1-cycle pulse at normal completion
//   step           out  3         0 IDLE,1 LYSIS,2 SETTLE_A,3 WASH,4 SETTLE_B,5 ELUTE,6 DONE
//   stroke_cnt     out  STROKE_W  completed strokes in current step
//   lysis_ctl, wash_ctl, elute_ctl, vertical_ctl, bead_trap_ctl,
//   collection_ctl, waste_ctl      out 1 each   valve control lines
//   pump1, pump2, pump3            out 1 each   peristaltic pump valves
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE; all *_ctl and pump lines = 1; busy = 0, done = 0, step = 0, stroke_cnt = 0.
//   All outputs are registered, with no combinational path from inputs.
//   IDLE: valves and pumps all 1. start=1 at an edge -> next cycle step=1, busy=1, valves open, pump phase 0.
//   Step valve maps (lines not listed are 1):
//     LYSIS: lysis, vertical, bead_trap, waste = 0.
//     WASH:  wash, vertical, bead_trap, waste = 0.
//     ELUTE: elute, vertical, bead_trap, collection = 0.
//     SETTLE_A/B: all lines 1, pumps 111; each lasts PHASE_CYC cycles.
//   Pump: one stroke = 6 phases of {pump1,pump2,pump3}: 110,100,101,001,011,010.
//     Each phase holds PHASE_CYC cycles, and at least one pump valve is always closed.
//     Outside pumping steps the pumps are 111.
//   Step length = STROKES*6*PHASE_CYC cycles.
//     stroke_cnt increments on the last cycle of phase 5.
//     stroke_cnt clears on every step change.
//   A step whose STROKES=0 is skipped: the FSM goes straight to the following state.
//   Sequence: LYSIS -> SETTLE_A -> WASH -> SETTLE_B -> ELUTE -> DONE -> IDLE.
//   DONE lasts 1 cycle: done=1, busy=0, all valves closed.
//   Defaults: busy high for 768+8+384+8+192 = 1360 cycles, then done for 1 cycle.
//   start while busy or DONE: ignored, with no restart.
//   abort=1 at an edge in any state: next cycle IDLE, all lines 1, stroke_cnt=0, done stays 0.
//     abort has priority over start in the same cycle.
//   Valve-map changes and pump resets take effect on the same edge as the state change.
//     No intermediate cycle with two reagent valves open ever occurs.
//   Invariant: at most one of lysis/wash/elute is 0.
//     collection and waste are never both 0.
// TESTING
//   1. Reset mid-ELUTE (rst_n low 1 cycle) -> all outputs at reset values immediately; restart works.
//   2. start pulse, defaults -> busy exactly 1360 cycles; done 1 cycle; stroke_cnt peaks at 16 / 8 / 4.
//   3. PHASE_CYC=1 -> pump pattern 110,100,101,001,011,010 repeats every 6 cycles; all-zero pump never seen.
//   4. abort at cycle 500 plus start in the same cycle -> IDLE next cycle, lines all 1, no done pulse.
//   5. WASH_STROKES=0 -> step goes 1,2,4,5,6 (WASH skipped); wash_ctl stays 1 throughout.
//   6. start held high continuously -> protocol restarts only after DONE->IDLE; invariants asserted every cycle.

Source files
------------

// File: rtl/nucleic_acid_valve_sequencer.sv
// Pneumatic valve and peristaltic pump sequencer for the nucleic_acid_3 chip.
// Runs LYSIS -> SETTLE_A -> WASH -> SETTLE_B -> ELUTE -> DONE; every output is a flop.
module nucleic_acid_valve_sequencer #(
  parameter int PHASE_CYC     = 8,
  parameter int PHASE_W       = 16,
  parameter int STROKE_W      = 8,
  parameter int LYSIS_STROKES = 16,
  parameter int WASH_STROKES  = 8,
  parameter int ELUTE_STROKES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [2:0]          step,
  output logic [STROKE_W-1:0] stroke_cnt,
  output logic                lysis_ctl,
  output logic                wash_ctl,
  output logic                elute_ctl,
  output logic                vertical_ctl,
  output logic                bead_trap_ctl,
  output logic                collection_ctl,
  output logic                waste_ctl,
  output logic                pump1,
  output logic                pump2,
  output logic                pump3
);

  // Encodings equal the externally visible step codes.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LYSIS    = 3'd1,
    S_SETTLE_A = 3'd2,
    S_WASH     = 3'd3,
    S_SETTLE_B = 3'd4,
    S_ELUTE    = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [PHASE_W-1:0]  phase_cnt_q, phase_cnt_d;
  logic [2:0]          phase_idx_q, phase_idx_d;
  logic [STROKE_W-1:0] strokes_q, strokes_d;

  // Registered output images, ordered {lysis,wash,elute,vertical,bead_trap,collection,waste}.
  logic [6:0]          ctl_q, ctl_d;
  logic [2:0]          pump_q, pump_d;
  logic                busy_d, done_d;
  logic [STROKE_W-1:0] sc_d;
  logic                phase_last, pumping_d;

  function automatic state_t after(state_t s);
    case (s)
      S_LYSIS:    return S_SETTLE_A;
      S_SETTLE_A: return S_WASH;
      S_WASH:     return S_SETTLE_B;
      S_SETTLE_B: return S_ELUTE;
      S_ELUTE:    return S_DONE;
      default:    return S_IDLE;
    endcase
  endfunction

  function automatic logic [STROKE_W-1:0] strokes_of(state_t s);
    case (s)
      S_LYSIS: return STROKE_W'(LYSIS_STROKES);
      S_WASH:  return STROKE_W'(WASH_STROKES);
      S_ELUTE: return STROKE_W'(ELUTE_STROKES);
      default: return '0;
    endcase
  endfunction

  // A pumping step with zero strokes is replaced by the state that follows it.
  function automatic state_t resolve(state_t s);
    if ((s == S_LYSIS || s == S_WASH || s == S_ELUTE) && strokes_of(s) == '0)
      return after(s);
    return s;
  endfunction

  function automatic logic [2:0] pump_pattern(logic [2:0] idx);
    case (idx)
      3'd0:    return 3'b110;
      3'd1:    return 3'b100;
      3'd2:    return 3'b101;
      3'd3:    return 3'b001;
      3'd4:    return 3'b011;
      3'd5:    return 3'b010;
      default: return 3'b111;
    endcase
  endfunction

  assign phase_last = (phase_cnt_q == PHASE_W'(PHASE_CYC - 1));

  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    phase_idx_d = phase_idx_q;
    strokes_d   = strokes_q;
    if (abort) begin
      state_d     = S_IDLE;
      phase_cnt_d = '0;
      phase_idx_d = '0;
      strokes_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d     = resolve(S_LYSIS);
            phase_cnt_d = '0;
            phase_idx_d = '0;
            strokes_d   = '0;
          end
        end
        S_LYSIS, S_WASH, S_ELUTE: begin
          if (phase_last) begin
            phase_cnt_d = '0;
            if (phase_idx_q == 3'd5) begin
              phase_idx_d = '0;
              if (strokes_q + STROKE_W'(1) == strokes_of(state_q)) begin
                state_d   = resolve(after(state_q));
                strokes_d = '0;
              end else begin
                strokes_d = strokes_q + STROKE_W'(1);
              end
            end else begin
              phase_idx_d = phase_idx_q + 3'd1;
            end
          end else begin
            phase_cnt_d = phase_cnt_q + PHASE_W'(1);
          end
        end
        S_SETTLE_A, S_SETTLE_B: begin
          if (phase_last) begin
            phase_cnt_d = '0;
            state_d     = resolve(after(state_q));
          end else begin
            phase_cnt_d = phase_cnt_q + PHASE_W'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    pumping_d = (state_d == S_LYSIS) || (state_d == S_WASH) || (state_d == S_ELUTE);
    busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d    = (state_d == S_DONE);
    pump_d    = pumping_d ? pump_pattern(phase_idx_d) : 3'b111;
    sc_d      = strokes_d;
    if (pumping_d && phase_idx_d == 3'd5 && phase_cnt_d == PHASE_W'(PHASE_CYC - 1))
      sc_d = strokes_d + STROKE_W'(1);
    case (state_d)
      S_LYSIS: ctl_d = 7'b0110010;
      S_WASH:  ctl_d = 7'b1010010;
      S_ELUTE: ctl_d = 7'b1100001;
      default: ctl_d = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      phase_cnt_q <= '0;
      phase_idx_q <= '0;
      strokes_q   <= '0;
      ctl_q       <= 7'b1111111;
      pump_q      <= 3'b111;
      busy        <= 1'b0;
      done        <= 1'b0;
      step        <= 3'd0;
      stroke_cnt  <= '0;
    end else begin
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      phase_idx_q <= phase_idx_d;
      strokes_q   <= strokes_d;
      ctl_q       <= ctl_d;
      pump_q      <= pump_d;
      busy        <= busy_d;
      done        <= done_d;
      step        <= state_d;
      stroke_cnt  <= sc_d;
    end
  end

  assign {lysis_ctl, wash_ctl, elute_ctl, vertical_ctl,
          bead_trap_ctl, collection_ctl, waste_ctl} = ctl_q;
  assign {pump1, pump2, pump3} = pump_q;

endmodule

// File: tb/tb_nucleic_acid_valve_sequencer.sv
// Bench for nucleic_acid_valve_sequencer: defaults, PHASE_CYC=1 and WASH_STROKES=0 instances.
// Handshake: start/abort are level inputs sampled at each rising edge; outputs sampled 1 ns after it.
module tb_nucleic_acid_valve_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 0, abort0 = 0, start1 = 0, abort1 = 0, start2 = 0, abort2 = 0;

  logic       busy0, done0, busy1, done1, busy2, done2;
  logic [2:0] step0, step1, step2;
  logic [7:0] sc0, sc1, sc2;
  logic [6:0] ctl0, ctl1, ctl2;
  logic [2:0] pmp0, pmp1, pmp2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nucleic_acid_valve_sequencer dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .busy(busy0), .done(done0), .step(step0), .stroke_cnt(sc0),
    .lysis_ctl(ctl0[6]), .wash_ctl(ctl0[5]), .elute_ctl(ctl0[4]), .vertical_ctl(ctl0[3]),
    .bead_trap_ctl(ctl0[2]), .collection_ctl(ctl0[1]), .waste_ctl(ctl0[0]),
    .pump1(pmp0[2]), .pump2(pmp0[1]), .pump3(pmp0[0]));

  nucleic_acid_valve_sequencer #(.PHASE_CYC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .busy(busy1), .done(done1), .step(step1), .stroke_cnt(sc1),
    .lysis_ctl(ctl1[6]), .wash_ctl(ctl1[5]), .elute_ctl(ctl1[4]), .vertical_ctl(ctl1[3]),
    .bead_trap_ctl(ctl1[2]), .collection_ctl(ctl1[1]), .waste_ctl(ctl1[0]),
    .pump1(pmp1[2]), .pump2(pmp1[1]), .pump3(pmp1[0]));

  nucleic_acid_valve_sequencer #(.WASH_STROKES(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .busy(busy2), .done(done2), .step(step2), .stroke_cnt(sc2),
    .lysis_ctl(ctl2[6]), .wash_ctl(ctl2[5]), .elute_ctl(ctl2[4]), .vertical_ctl(ctl2[3]),
    .bead_trap_ctl(ctl2[2]), .collection_ctl(ctl2[1]), .waste_ctl(ctl2[0]),
    .pump1(pmp2[2]), .pump2(pmp2[1]), .pump3(pmp2[0]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic inv(input string tag, input logic [6:0] c, input logic [2:0] p,
                     input logic b, input logic d);
    chk({tag, "_one_reagent"}, 32'(($countones(~c[6:4]) <= 1)), 1);
    chk({tag, "_coll_waste"}, 32'(!(c[1] == 1'b0 && c[0] == 1'b0)), 1);
    chk({tag, "_pump_nonzero"}, 32'(p != 3'b000), 1);
    chk({tag, "_busy_done"}, 32'(!(b && d)), 1);
  endtask

  // Safety invariants on every instance, every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      inv("inv0", ctl0, pmp0, busy0, done0);
      inv("inv1", ctl1, pmp1, busy1, done1);
      inv("inv2", ctl2, pmp2, busy2, done2);
    end
  end

  typedef struct {
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic [2:0] step;
    logic [7:0] sc;
    logic [6:0] ctl;
    logic [2:0] pump;
  } vec_t;

  localparam logic [6:0] ALL1 = 7'b1111111;
  localparam logic [6:0] LYS  = 7'b0110010;

  vec_t tbl[10];
  logic [2:0] pat[6];
  logic [2:0] exp_q[$];

  initial begin
    int n, k, bcnt, dcnt, wlow;
    logic [2:0] prev;
    logic [7:0] mx1, mx3, mx5;

    tbl[0] = '{0, 0, 0, 0, 3'd0, 8'd0, ALL1, 3'b111};
    tbl[1] = '{1, 0, 1, 0, 3'd1, 8'd0, LYS,  3'b110};
    tbl[2] = '{0, 0, 1, 0, 3'd1, 8'd0, LYS,  3'b100};
    tbl[3] = '{0, 0, 1, 0, 3'd1, 8'd0, LYS,  3'b101};
    tbl[4] = '{0, 0, 1, 0, 3'd1, 8'd0, LYS,  3'b001};
    tbl[5] = '{0, 0, 1, 0, 3'd1, 8'd0, LYS,  3'b011};
    tbl[6] = '{0, 0, 1, 0, 3'd1, 8'd1, LYS,  3'b010};
    tbl[7] = '{0, 0, 1, 0, 3'd1, 8'd1, LYS,  3'b110};
    tbl[8] = '{1, 1, 0, 0, 3'd0, 8'd0, ALL1, 3'b111};
    tbl[9] = '{0, 0, 0, 0, 3'd0, 8'd0, ALL1, 3'b111};
    pat[0] = 3'b110; pat[1] = 3'b100; pat[2] = 3'b101;
    pat[3] = 3'b001; pat[4] = 3'b011; pat[5] = 3'b010;

    // Reset values while rst_n is held low.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_step", step0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_sc", sc0, 0);
    chk("rst_ctl", ctl0, ALL1);
    chk("rst_pump", pmp0, 3'b111);
    rst_n = 1'b1;
    tick();

    // Table on the PHASE_CYC=1 instance: first stroke, then abort+start together.
    for (int i = 0; i < 10; i++) begin
      start1 = tbl[i].start;
      abort1 = tbl[i].abort;
      tick();
      chk($sformatf("tbl%0d_busy", i), busy1, tbl[i].busy);
      chk($sformatf("tbl%0d_done", i), done1, tbl[i].done);
      chk($sformatf("tbl%0d_step", i), step1, tbl[i].step);
      chk($sformatf("tbl%0d_sc", i), sc1, tbl[i].sc);
      chk($sformatf("tbl%0d_ctl", i), ctl1, tbl[i].ctl);
      chk($sformatf("tbl%0d_pump", i), pmp1, tbl[i].pump);
    end
    start1 = 0;
    abort1 = 0;

    // Full run at PHASE_CYC=1 against a pump-phase model.
    start1 = 1;
    tick();
    start1 = 0;
    k = 0; n = 0; dcnt = 0; prev = 3'd1;
    while (step1 != 3'd0 && n < 400) begin
      if (step1 != prev) k = 0;
      if (step1 == 3'd1 || step1 == 3'd3 || step1 == 3'd5)
        chk($sformatf("pc1_pump_n%0d", n), pmp1, pat[k % 6]);
      else
        chk($sformatf("pc1_pump_idle_n%0d", n), pmp1, 3'b111);
      if (done1) dcnt++;
      prev = step1;
      k++; n++;
      tick();
    end
    chk("pc1_len", n, 171);
    chk("pc1_done_pulses", dcnt, 1);

    // Default run: busy length, stroke peaks, stroke timing, ignored start.
    start0 = 1;
    tick();
    start0 = 0;
    bcnt = 0; mx1 = 0; mx3 = 0; mx5 = 0;
    while (busy0 && bcnt < 2000) begin
      if (step0 == 3'd1 && sc0 > mx1) mx1 = sc0;
      if (step0 == 3'd3 && sc0 > mx3) mx3 = sc0;
      if (step0 == 3'd5 && sc0 > mx5) mx5 = sc0;
      if (bcnt == 46) chk("sc_before_first", sc0, 0);
      if (bcnt == 47) chk("sc_first_stroke", sc0, 1);
      if (bcnt == 768) begin
        chk("settle_a_step", step0, 2);
        chk("settle_a_ctl", ctl0, ALL1);
        chk("settle_a_pump", pmp0, 3'b111);
        chk("settle_a_sc", sc0, 0);
      end
      start0 = (bcnt == 100);
      bcnt++;
      tick();
    end
    start0 = 0;
    chk("busy_len", bcnt, 1360);
    chk("peak_lysis", mx1, 16);
    chk("peak_wash", mx3, 8);
    chk("peak_elute", mx5, 4);
    chk("done_pulse", done0, 1);
    chk("done_step", step0, 6);
    chk("done_ctl", ctl0, ALL1);
    tick();
    chk("after_done", done0, 0);
    chk("after_done_step", step0, 0);

    // WASH_STROKES=0: WASH skipped, wash valve never opens.
    start2 = 1;
    tick();
    start2 = 0;
    exp_q = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
    prev = 3'd0; n = 0; wlow = 0; bcnt = 0;
    while (step2 != 3'd0 && n < 3000) begin
      if (step2 != prev) begin
        if (exp_q.size() == 0) chk("skip_extra_step", step2, 0);
        else chk($sformatf("skip_seq_%0d", n), step2, exp_q.pop_front());
      end
      if (!ctl2[5]) wlow++;
      if (busy2) bcnt++;
      prev = step2;
      n++;
      tick();
    end
    chk("skip_seq_left", exp_q.size(), 0);
    chk("skip_wash_low", wlow, 0);
    chk("skip_busy_len", bcnt, 976);

    // Abort with simultaneous start 500 cycles in.
    start0 = 1;
    tick();
    start0 = 0;
    repeat (500) tick();
    chk("pre_abort_busy", busy0, 1);
    start0 = 1;
    abort0 = 1;
    tick();
    start0 = 0;
    abort0 = 0;
    chk("abort_step", step0, 0);
    chk("abort_busy", busy0, 0);
    chk("abort_ctl", ctl0, ALL1);
    chk("abort_pump", pmp0, 3'b111);
    chk("abort_sc", sc0, 0);
    dcnt = 0;
    for (int i = 0; i < 1500; i++) begin
      if (done0 || busy0) dcnt++;
      tick();
    end
    chk("abort_no_activity", dcnt, 0);

    // start held high: restart only after DONE -> IDLE.
    start0 = 1;
    tick();
    bcnt = 0;
    while (busy0 && bcnt < 2000) begin
      bcnt++;
      tick();
    end
    chk("held_busy_len", bcnt, 1360);
    chk("held_done", done0, 1);
    tick();
    chk("held_idle_step", step0, 0);
    chk("held_idle_busy", busy0, 0);
    tick();
    chk("held_restart_step", step0, 1);
    start0 = 0;
    abort0 = 1;
    tick();
    abort0 = 0;

    // Reset mid-ELUTE, then restart.
    start0 = 1;
    tick();
    start0 = 0;
    n = 0;
    while (step0 != 3'd5 && n < 2000) begin
      n++;
      tick();
    end
    chk("reach_elute", step0, 5);
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_step", step0, 0);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_sc", sc0, 0);
    chk("mid_rst_ctl", ctl0, ALL1);
    chk("mid_rst_pump", pmp0, 3'b111);
    tick();
    rst_n = 1'b1;
    tick();
    start0 = 1;
    tick();
    start0 = 0;
    chk("restart_step", step0, 1);
    chk("restart_busy", busy0, 1);
    chk("restart_pump", pmp0, 3'b110);
    chk("restart_ctl", ctl0, LYS);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
